// File: rtl/itag_ctl.sv
// Instruction-cache tag controller: hit/miss compare, linefill request, tag update, invalidate sweep.
// Hit/miss one cycle after acceptance (one lookup per 2 cycles); req_ready low whenever not IDLE.
module itag_ctl #(
   parameter int NL  = 128,
   parameter int LSS = 7,
   parameter int LSH = LSS + 4,
   parameter int PSL = LSH + 1,
   parameter int TS  = 2 + (32 - PSL)
) (
   input  logic           nGCLK,
   input  logic           reset,
   input  logic           req_valid,
   input  logic [31:0]    req_addr,
   output logic           req_ready,
   output logic           hit,
   output logic           miss,
   output logic [LSS-1:0] line_sel,
   output logic           busy,
   input  logic           inv_all,
   output logic           fill_req,
   output logic [31:0]    fill_addr,
   input  logic           fill_done,
   output logic [LSS-1:0] tag_read_sel,
   input  logic [TS-1:0]  tag_read_port,
   output logic [LSS-1:0] tag_write_sel,
   output logic [TS-1:0]  tag_write_port,
   output logic           tag_wr_ena
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_FILL, S_UPDATE} state_t;

   state_t         r_state, w_state_nxt;
   logic [LSS-1:0] r_cnt, w_cnt_nxt;
   logic           r_pend_inv, w_pend_inv_nxt;
   logic [31:5]    r_addr_q;
   logic           w_accept;
   logic           w_tag_hit;
   logic           w_unused;

   // Dirty bit is never consumed here and byte/word offsets never reach the tag path.
   assign w_unused  = ^{req_addr[4:0], tag_read_port[TS-1]};

   assign w_tag_hit = tag_read_port[TS-2] && (tag_read_port[TS-3:0] == r_addr_q[31:PSL]);
   assign line_sel  = r_addr_q[LSH:LSH-LSS+1];
   assign fill_addr = {r_addr_q, 5'b0};

   always_ff @(posedge nGCLK) begin
      if (reset) begin
         r_state    <= S_INIT;
         r_cnt      <= '0;
         r_pend_inv <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pend_inv <= w_pend_inv_nxt;
      end
   end

   always_ff @(posedge nGCLK) begin
      if (w_accept)
         r_addr_q <= req_addr[31:5];
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pend_inv_nxt = r_pend_inv;
      w_accept       = 1'b0;
      req_ready      = 1'b0;
      hit            = 1'b0;
      miss           = 1'b0;
      busy           = 1'b0;
      fill_req       = 1'b0;
      tag_wr_ena     = 1'b0;
      tag_write_sel  = line_sel;
      tag_write_port = '0;
      tag_read_sel   = line_sel;

      case (r_state)
         S_INIT: begin
            busy          = 1'b1;
            tag_wr_ena    = 1'b1;
            tag_write_sel = r_cnt;
            tag_read_sel  = r_cnt;
            w_cnt_nxt     = r_cnt + 1'b1;
            if (r_cnt == LSS'(NL - 1))
               w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            // Read select comes straight from the request so data is ready in LOOKUP.
            tag_read_sel = req_addr[LSH:LSH-LSS+1];
            if (inv_all) begin
               w_state_nxt = S_INIT;
               w_cnt_nxt   = '0;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (w_tag_hit) begin
               hit         = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               miss        = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            busy     = 1'b1;
            fill_req = 1'b1;
            if (inv_all)
               w_pend_inv_nxt = 1'b1;
            if (fill_done)
               w_state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            busy           = 1'b1;
            tag_wr_ena     = 1'b1;
            tag_write_port = {1'b0, 1'b1, r_addr_q[31:PSL]};
            hit            = 1'b1;
            if (r_pend_inv) begin
               w_state_nxt    = S_INIT;
               w_cnt_nxt      = '0;
               w_pend_inv_nxt = 1'b0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs are forced quiet while reset is held, whatever state the flops hold.
      if (reset) begin
         w_accept   = 1'b0;
         req_ready  = 1'b0;
         hit        = 1'b0;
         miss       = 1'b0;
         fill_req   = 1'b0;
         tag_wr_ena = 1'b0;
         busy       = 1'b1;
      end
   end

endmodule

// File: doc/itag_ctl.md
Name: itag_ctl

Overview:
- Tag lookup and update controller for the instruction cache. It drives the read and write selects of the tag memory and consumes its read port.
- Performs hit/miss compare, requests linefills on miss, and writes the new tag when a fill completes.
- Performs an invalidate-all sweep after reset or on request.
- Sits between the fetch unit, the tag memory and the linefill engine.

Parameters:
NL, 128, number of cache lines
LSS, 7, line select bits = log2(NL)
LSH, LSS+4, high bit of line select in address (<tag><LSS><word><byte>)
PSL, LSH+1, low bit of page select
TS, 2+(32-PSL), tag width: {D, V, page[31:PSL]}

Ports:
nGCLK  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch lookup request
req_addr  in  32  fetch address
req_ready  out  1  controller can accept a request this cycle
hit  out  1  one-cycle pulse: line for latched address is valid
miss  out  1  one-cycle pulse: lookup missed
line_sel  out  LSS  line index of latched request (addr_q[LSH:LSH-LSS+1])
busy  out  1  high in INIT, FILL, UPDATE
inv_all  in  1  invalidate entire cache
fill_req  out  1  linefill request, level
fill_addr  out  32  line-aligned fill address {addr_q[31:5],5'b0}
fill_done  in  1  linefill complete, one-cycle pulse
tag_read_sel  out  LSS  tag memory read select
tag_read_port  in  TS  tag memory read data, valid one cycle after select sampled
tag_write_sel  out  LSS  tag memory write select
tag_write_port  out  TS  tag memory write data
tag_wr_ena  out  1  tag memory write enable

Behaviour:
- One clock (nGCLK). Synchronous active-high reset.
- Tag fields: bit TS-1 = D (always written 0), bit TS-2 = V, bits [TS-3:0] = addr[31:PSL].
- While reset is high:
  - state <= INIT, counter <= 0, pending_inv <= 0.
  - hit, miss, fill_req, tag_wr_ena, req_ready = 0; busy = 1.
- INIT:
  - Each cycle: tag_wr_ena=1, tag_write_sel=counter, tag_write_port=0, counter++.
  - After the write at counter=NL-1, go to IDLE.
  - The sweep takes exactly NL cycles after reset falls.
- IDLE:
  - req_ready=1.
  - tag_read_sel is combinational from req_addr[LSH:LSH-LSS+1].
  - If inv_all: go to INIT with counter=0. inv_all has priority over req_valid; req_ready=0 that cycle.
  - Else if req_valid: latch addr_q, go to LOOKUP.
- LOOKUP:
  - tag_read_sel holds line_sel.
  - Hit when V=1 and page==addr_q[31:PSL]: hit=1, go to IDLE.
  - Otherwise: miss=1, go to FILL.
  - Result: hit/miss is seen one cycle after acceptance; throughput is one lookup per 2 cycles.
- FILL:
  - fill_req=1 and fill_addr is stable until the cycle fill_done is sampled high; fill_req drops the next cycle.
  - On fill_done, go to UPDATE.
  - inv_all in FILL sets pending_inv; the fill is not aborted.
- UPDATE:
  - Single cycle: tag_wr_ena=1, tag_write_sel=line_sel, tag_write_port={1'b0,1'b1,addr_q[31:PSL]}, hit=1.
  - Next state is INIT if pending_inv (cleared on entry), else IDLE.
- Whenever tag_wr_ena=1, tag_read_sel equals tag_write_sel.
- Back-to-back same line: a request accepted in the IDLE cycle after UPDATE must see the new tag.
- fill_done outside FILL is ignored.
- req_valid outside IDLE is not accepted; the requester holds it.
- Reset in any state (including mid-FILL): fill_req low the next cycle, sweep restarts at line 0.
- hit and miss are never high together. They are registered-state decodes with no combinational path from req_valid.

Test Plan:
1. Reset 2 cycles, then release -> exactly 128 writes of 22'h000000 to lines 0..127 in order; req_ready first high 128 cycles after reset falls; busy high throughout the sweep.
2. Cold request 32'h0000_1A40 -> line 0x52, miss pulse, fill_req with fill_addr 32'h0000_1A40. fill_done 5 cycles later -> UPDATE writes 22'h100001 to line 0x52 with hit=1 that cycle.
3. Request 32'h0000_1A5C right after -> hit one cycle after acceptance; no fill_req; no tag_wr_ena.
4. Request 32'h0000_2A40 (same line, page 2) -> miss, fill, line 0x52 overwritten with 22'h100002. Then request 32'h0000_1A40 -> miss.
5. inv_all pulsed in FILL -> fill completes, UPDATE writes tag, then a 128-cycle sweep follows. The next request to 32'h0000_1A40 misses. Also: inv_all and req_valid together in IDLE -> sweep, request not accepted.
6. Reset asserted 2 cycles into FILL -> fill_req low the next cycle. fill_done arriving during INIT is ignored. Sweep restarts at line 0 and lasts 128 cycles.
